speck_hash_engine: RTL

SPECK_HASH_ENGINE -- requirements
Module: speck_hash_engine

---
 rtl/speck_hash_engine_if.sv | 26 ++
 rtl/speck_hash_engine.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/speck_hash_engine_if.sv
// Handshake and operand bundle between a hash requester and speck_hash_engine.
interface speck_hash_engine_if #(
  parameter int unsigned W     = 64,
  parameter int unsigned OUT_W = 4
) ();
  logic             start;
  logic [W-1:0]     x_in;
  logic [W-1:0]     y_in;
  logic [W-1:0]     k_in;
  logic [W-1:0]     h_in;
  logic             busy;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             done;

  modport master (
    output start, x_in, y_in, k_in, h_in, dout_ready,
    input  busy, dout, dout_valid, done
  );

  modport slave (
    input  start, x_in, y_in, k_in, h_in, dout_ready,
    output busy, dout, dout_valid, done
  );
endinterface

// File: rtl/speck_hash_engine.sv
// SPECK-style round/compression hash with a digest streamed out in OUT_W-bit beats.
// Two-process FSM: one register bank, one next-state/output block.
module speck_hash_engine #(
  parameter int unsigned W       = 64,
  parameter int unsigned ROUNDS  = 8,
  parameter int unsigned CROUNDS = 4,
  parameter int unsigned ALPHA   = 7,
  parameter int unsigned BETA    = 2,
  parameter int unsigned OUT_W   = 4,
  parameter int unsigned ROT     = 1
) (
  input logic               clk,
  input logic               reset,
  speck_hash_engine_if.slave bus
);

  localparam int unsigned BEATS   = W / OUT_W;
  localparam int unsigned RC_MAX  = (ROUNDS > CROUNDS) ? ROUNDS : CROUNDS;
  localparam int unsigned CNT_MAX = (RC_MAX > BEATS) ? RC_MAX : BEATS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ROUND, MIX, COMP, STREAM} state_t;

  state_t           state, state_n;
  logic [W-1:0]     x, x_n, y, y_n, k, k_n, h, h_n;
  logic [W-1:0]     hacc, hacc_n, digest, digest_n;
  logic [CNT_W-1:0] cnt, cnt_n, beat, beat_n;
  logic             busy_q, busy_n, valid_q, valid_n, done_q, done_n;
  logic [OUT_W-1:0] dout_q, dout_n;
  logic [W-1:0]     x_rnd, y_rnd, hacc_rnd;

  // R and L: rotate when ROT is set, otherwise zero-filling shift
  function automatic logic [W-1:0] op_r(input logic [W-1:0] v);
    op_r = (ROT != 0) ? ((v >> ALPHA) | (v << (W - ALPHA))) : (v >> ALPHA);
  endfunction

  function automatic logic [W-1:0] op_l(input logic [W-1:0] v);
    op_l = (ROT != 0) ? ((v << BETA) | (v >> (W - BETA))) : (v << BETA);
  endfunction

  assign x_rnd    = (op_r(x) + y) ^ k;
  assign y_rnd    = op_l(y) ^ x_rnd;
  assign hacc_rnd = (op_r(hacc) + k) ^ op_l(hacc);

  assign bus.busy       = busy_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.done       = done_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      k       <= '0;
      h       <= '0;
      hacc    <= '0;
      digest  <= '0;
      cnt     <= '0;
      beat    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state   <= state_n;
      x       <= x_n;
      y       <= y_n;
      k       <= k_n;
      h       <= h_n;
      hacc    <= hacc_n;
      digest  <= digest_n;
      cnt     <= cnt_n;
      beat    <= beat_n;
      busy_q  <= busy_n;
      valid_q <= valid_n;
      done_q  <= done_n;
      dout_q  <= dout_n;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    k_n      = k;
    h_n      = h;
    hacc_n   = hacc;
    digest_n = digest;
    cnt_n    = cnt;
    beat_n   = beat;
    busy_n   = busy_q;
    valid_n  = valid_q;
    done_n   = 1'b0;
    dout_n   = dout_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          x_n     = bus.x_in;
          y_n     = bus.y_in;
          k_n     = bus.k_in;
          h_n     = bus.h_in;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = ROUND;
        end
      end
      ROUND: begin
        x_n = x_rnd;
        y_n = y_rnd;
        if (cnt == CNT_W'(ROUNDS - 1)) begin
          cnt_n   = '0;
          state_n = MIX;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      MIX: begin
        hacc_n  = x ^ y ^ h;
        cnt_n   = '0;
        state_n = COMP;
      end
      COMP: begin
        // The cycle after the last compression round publishes the digest
        if (cnt == CNT_W'(CROUNDS)) begin
          digest_n = hacc;
          beat_n   = '0;
          dout_n   = hacc[OUT_W-1:0];
          valid_n  = 1'b1;
          state_n  = STREAM;
        end else begin
          hacc_n = hacc_rnd;
          cnt_n  = cnt + CNT_W'(1);
        end
      end
      STREAM: begin
        if (bus.dout_ready) begin
          if (beat == CNT_W'(BEATS - 1)) begin
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            beat_n = beat + CNT_W'(1);
            dout_n = OUT_W'(digest >> (OUT_W * (32'(beat) + 32'd1)));
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
